// File: rtl/simd_perm_sched_pkg.sv
// Shared types for the SIMD permutation scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: vector geometry constants, permutation mode enum, request struct, scheduler FSM states.
package simd_perm_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned NumInOuts = 64;

  typedef enum logic [2:0] {
    PERM_MODE_0 = 3'd0,
    PERM_MODE_1 = 3'd1,
    PERM_MODE_2 = 3'd2,
    PERM_MODE_3 = 3'd3,
    PERM_MODE_4 = 3'd4,
    PERM_MODE_5 = 3'd5,
    PERM_MODE_6 = 3'd6,
    PERM_MODE_7 = 3'd7
  } perm_mode_e;

  typedef struct packed {
    logic                              sel_idx;
    logic                              permute;
    perm_mode_e                        mode;
    logic [NumInOuts-1:0][XLEN-1:0]    data;
  } perm_req_t;

  typedef enum logic {
    SCHED_RUN   = 1'b0,
    SCHED_DRAIN = 1'b1
  } sched_state_e;

endpackage

// File: rtl/simd_perm_sched_tag_fifo.sv
// In-order id FIFO tracking which requester owns each result still inside the datapath.
// Latency: push visible at head_o the cycle after the push; pop takes effect at the clock edge.
// Backpressure: pushes while full and pops while empty are ignored; the owner gates on full_o/empty_o.
// Ports: clk_i/rst_ni, push_i/push_dat_i, pop_i, head_o (oldest id), occ_o, full_o, empty_o.
module perm_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [Width-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             head_o,
  output logic [$clog2(Depth+1)-1:0]   occ_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [OccW-1:0]  occ_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (occ_q == OccW'(Depth));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/simd_perm_sched.sv
// Shares one SIMD permutation datapath between NumReq requesters with round-robin issue and in-order result routing.
// Latency: accept in cycle N -> perm_in_valid_o in N+1; result path perm_out_* -> rsp_* is combinational.
// Backpressure: issue stalls on perm_in_ready_i or a full tag FIFO; results stall on the owner's rsp_ready_i.
// Ports: req_* (requester side, valid/ready), rsp_* (per-requester valid, shared data bus),
//        perm_in_* / perm_out_* (datapath input and output handshakes). Mode changes and index loads
//        first drain the datapath so no in-flight vector sees a reconfigured permutation.
module simd_perm_sched
  import simd_perm_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned MaxInflight = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NumReq-1:0]                          req_valid_i,
  output logic [NumReq-1:0]                          req_ready_o,
  input  logic [NumReq-1:0]                          req_sel_idx_i,
  input  logic [NumReq-1:0]                          req_permute_i,
  input  logic [NumReq-1:0][2:0]                     req_mode_i,
  input  logic [NumReq-1:0][NumInOuts-1:0][XLEN-1:0] req_data_i,
  output logic [NumReq-1:0]                          rsp_valid_o,
  input  logic [NumReq-1:0]                          rsp_ready_i,
  output logic [NumInOuts-1:0][XLEN-1:0]             rsp_data_o,
  output logic                                       perm_in_valid_o,
  input  logic                                       perm_in_ready_i,
  output logic                                       perm_sel_idx_val_o,
  output logic                                       perm_permute_o,
  output logic [2:0]                                 perm_mode_o,
  output logic [NumInOuts-1:0][XLEN-1:0]             perm_in_data_o,
  input  logic                                       perm_out_valid_i,
  output logic                                       perm_out_ready_o,
  input  logic [NumInOuts-1:0][XLEN-1:0]             perm_out_data_i
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned OccW = $clog2(MaxInflight + 1);

  sched_state_e    state_q;
  logic [IdW-1:0]  lock_id_q;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  perm_mode_e      cur_mode_q;
  logic            stg_valid_q;
  logic [IdW-1:0]  stg_id_q;
  perm_req_t       stg_q, stg_d;

  logic            cand_vld, reconf, go_drain, drain_done;
  logic [IdW-1:0]  cand_id, cand_scan, acc_id;
  logic            acc_vld, stg_fire, stage_free;
  logic            tag_push, tag_pop;
  logic [IdW-1:0]  fifo_head;
  logic [OccW-1:0] fifo_occ;
  logic            fifo_full, fifo_empty;

  // Round-robin: scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    cand_vld  = 1'b0;
    cand_id   = '0;
    cand_scan = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand_scan = IdW'((int'(rr_ptr_q) + k) % NumReq);
      if (req_valid_i[cand_scan]) begin
        cand_vld = 1'b1;
        cand_id  = cand_scan;
      end
    end
  end

  assign reconf     = req_sel_idx_i[cand_id] | (req_mode_i[cand_id] != cur_mode_q);
  assign stg_fire   = perm_in_valid_o & perm_in_ready_i;
  assign stage_free = ~stg_valid_q | stg_fire;
  assign drain_done = (state_q == SCHED_DRAIN) & ~stg_valid_q & fifo_empty;
  assign go_drain   = (state_q == SCHED_RUN) & cand_vld & reconf;

  // rst_ni gates the grant so req_ready_o is low for the whole reset, not just after the first edge.
  always_comb begin
    acc_vld = 1'b0;
    acc_id  = cand_id;
    if (state_q == SCHED_RUN) begin
      acc_vld = cand_vld & ~reconf & stage_free;
    end else begin
      acc_id  = lock_id_q;
      acc_vld = drain_done & req_valid_i[lock_id_q];
    end
    acc_vld = acc_vld & rst_ni;
  end

  always_comb begin
    req_ready_o = '0;
    if (acc_vld) req_ready_o[acc_id] = 1'b1;
  end

  always_comb begin
    stg_d         = stg_q;
    stg_d.sel_idx = req_sel_idx_i[acc_id];
    stg_d.permute = req_permute_i[acc_id];
    stg_d.mode    = perm_mode_e'(req_mode_i[acc_id]);
    stg_d.data    = req_data_i[acc_id];
  end

  assign rr_ptr_d = (acc_id == IdW'(NumReq - 1)) ? '0 : acc_id + IdW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCHED_RUN;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      cur_mode_q  <= PERM_MODE_0;
      stg_valid_q <= 1'b0;
      stg_id_q    <= '0;
      stg_q       <= '0;
    end else begin
      if (stg_fire) stg_valid_q <= 1'b0;
      if (acc_vld) begin
        stg_valid_q <= 1'b1;
        stg_id_q    <= acc_id;
        stg_q       <= stg_d;
        rr_ptr_q    <= rr_ptr_d;
      end
      case (state_q)
        SCHED_RUN: begin
          if (go_drain) begin
            state_q   <= SCHED_DRAIN;
            lock_id_q <= cand_id;
          end
        end
        SCHED_DRAIN: begin
          if (drain_done) begin
            state_q <= SCHED_RUN;
            if (acc_vld) cur_mode_q <= perm_mode_e'(req_mode_i[lock_id_q]);
          end
        end
        default: state_q <= SCHED_RUN;
      endcase
    end
  end

  // Credit uses registered occupancy only: a pop frees a slot for issue one cycle later.
  assign perm_in_valid_o    = stg_valid_q & (fifo_occ < OccW'(MaxInflight));
  assign perm_sel_idx_val_o = stg_q.sel_idx;
  assign perm_permute_o     = stg_q.permute;
  assign perm_mode_o        = stg_q.mode;
  assign perm_in_data_o     = stg_q.data;

  // Index loads produce no result, so they take no tag.
  assign tag_push = stg_fire & ~stg_q.sel_idx;
  assign tag_pop  = perm_out_valid_i & perm_out_ready_o;

  perm_tag_fifo #(
    .Depth (MaxInflight),
    .Width (IdW)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (tag_push),
    .push_dat_i (stg_id_q),
    .pop_i      (tag_pop),
    .head_o     (fifo_head),
    .occ_o      (fifo_occ),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign perm_out_ready_o = ~fifo_empty & rsp_ready_i[fifo_head];
  assign rsp_data_o       = perm_out_data_i;

  always_comb begin
    rsp_valid_o = '0;
    if (perm_out_valid_i && !fifo_empty) rsp_valid_o[fifo_head] = 1'b1;
  end

  // A result with no outstanding tag has no owner; it is dropped and never acknowledged.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(perm_out_valid_i && fifo_empty));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(tag_push && fifo_full));

endmodule

// File: tb/tb_simd_perm_sched.sv
module tb_simd_perm_sched;
  import simd_perm_pkg::*;

  typedef logic [NumInOuts-1:0][XLEN-1:0] vec_t;

  logic                 clk_i;
  logic                 rst_ni;
  logic [1:0]           req_valid_i;
  logic [1:0]           req_ready_o;
  logic [1:0]           req_sel_idx_i;
  logic [1:0]           req_permute_i;
  logic [1:0][2:0]      req_mode_i;
  logic [1:0][NumInOuts-1:0][XLEN-1:0] req_data_i;
  logic [1:0]           rsp_valid_o;
  logic [1:0]           rsp_ready_i;
  vec_t                 rsp_data_o;
  logic                 perm_in_valid_o;
  logic                 perm_in_ready_i;
  logic                 perm_sel_idx_val_o;
  logic                 perm_permute_o;
  logic [2:0]           perm_mode_o;
  vec_t                 perm_in_data_o;
  logic                 perm_out_valid_i;
  logic                 perm_out_ready_o;
  vec_t                 perm_out_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  simd_perm_sched #(.NumReq(2), .MaxInflight(4)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_sel_idx_i      (req_sel_idx_i),
    .req_permute_i      (req_permute_i),
    .req_mode_i         (req_mode_i),
    .req_data_i         (req_data_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_data_o         (rsp_data_o),
    .perm_in_valid_o    (perm_in_valid_o),
    .perm_in_ready_i    (perm_in_ready_i),
    .perm_sel_idx_val_o (perm_sel_idx_val_o),
    .perm_permute_o     (perm_permute_o),
    .perm_mode_o        (perm_mode_o),
    .perm_in_data_o     (perm_in_data_o),
    .perm_out_valid_i   (perm_out_valid_i),
    .perm_out_ready_o   (perm_out_ready_o),
    .perm_out_data_i    (perm_out_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vec_t mkvec(input int unsigned seed);
    vec_t v;
    for (int i = 0; i < NumInOuts; i++) v[i] = {32'(seed), 32'(i)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    n_tests++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 00", req_ready_o); end
    n_tests++; if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid_o); end
    n_tests++; if (perm_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_valid: got %b exp 0", perm_in_valid_o); end
    n_tests++; if (perm_out_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_ready: got %b exp 0", perm_out_ready_o); end
    n_tests++; if (perm_in_data_o !== '0) begin n_fail++; $display("FAIL rst_in_data: got word0 %h exp 0", perm_in_data_o[0]); end
    n_tests++; if ({perm_mode_o, perm_permute_o, perm_sel_idx_val_o} !== 5'b0) begin n_fail++; $display("FAIL rst_fields: got %b exp 0", {perm_mode_o, perm_permute_o, perm_sel_idx_val_o}); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid_i = 2'b01; req_permute_i = 2'b11; req_mode_i = '0; req_data_i[0] = mkvec(1);
    #1;
    n_tests++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL single_accept: got %b exp 01", req_ready_o); end
    tick();
    req_valid_i = 2'b00;
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_issue_valid: got %b exp 1", perm_in_valid_o); end
    n_tests++; if (perm_in_data_o !== mkvec(1)) begin n_fail++; $display("FAIL single_issue_data: got word0 %h exp %h", perm_in_data_o[0], mkvec(1) ); end
    n_tests++; if ({perm_mode_o, perm_permute_o, perm_sel_idx_val_o} !== 5'b00010) begin n_fail++; $display("FAIL single_fields: got %b exp 00010", {perm_mode_o, perm_permute_o, perm_sel_idx_val_o}); end
    tick();
    perm_out_valid_i = 1'b1; perm_out_data_i = mkvec(2);
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_stage_empty: got %b exp 0", perm_in_valid_o); end
    n_tests++; if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b exp 01", rsp_valid_o); end
    n_tests++; if (rsp_data_o !== mkvec(2)) begin n_fail++; $display("FAIL single_rsp_data: got word0 %h", rsp_data_o[0]); end
    n_tests++; if (perm_out_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_out_ready: got %b exp 1", perm_out_ready_o); end
    tick();
    perm_out_valid_i = 1'b0;
    #1;
    n_tests++; if (perm_out_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_fifo_empty: got %b exp 0", perm_out_ready_o); end
  endtask

  // Round-robin pointer is 1 here (last grant was requester 0), so grants run 1,0,1,0,1,0.
  task automatic test_contention();
    int g, sid;
    req_mode_i = '0; req_data_i[0] = mkvec(10); req_data_i[1] = mkvec(11);
    for (int cyc = 0; cyc < 8; cyc++) begin
      req_valid_i      = (cyc < 6) ? 2'b11 : 2'b00;
      perm_out_valid_i = (cyc >= 2);
      perm_out_data_i  = mkvec(20 + cyc);
      #1;
      g   = (cyc % 2 == 0) ? 1 : 0;
      sid = 1 - g;
      if (cyc < 6) begin
        n_tests++; if (req_ready_o !== 2'(1 << g)) begin n_fail++; $display("FAIL cont_grant c%0d: got %b exp %b", cyc, req_ready_o, 2'(1 << g)); end
      end
      if (cyc >= 1 && cyc < 7) begin
        n_tests++; if (perm_in_valid_o !== 1'b1) begin n_fail++; $display("FAIL cont_in_valid c%0d: got %b exp 1", cyc, perm_in_valid_o); end
        n_tests++; if (perm_in_data_o !== mkvec(10 + sid)) begin n_fail++; $display("FAIL cont_in_data c%0d: got word0 %h exp req%0d", cyc, perm_in_data_o[0], sid); end
      end
      if (cyc >= 2) begin
        n_tests++; if (rsp_valid_o !== 2'(1 << g)) begin n_fail++; $display("FAIL cont_rsp c%0d: got %b exp %b", cyc, rsp_valid_o, 2'(1 << g)); end
        n_tests++; if (rsp_data_o !== mkvec(20 + cyc)) begin n_fail++; $display("FAIL cont_rsp_data c%0d: got word0 %h", cyc, rsp_data_o[0]); end
      end
      tick();
    end
    perm_out_valid_i = 1'b0;
    #1;
    n_tests++; if ({perm_out_ready_o, perm_in_valid_o} !== 2'b00) begin n_fail++; $display("FAIL cont_idle: got %b exp 00", {perm_out_ready_o, perm_in_valid_o}); end
  endtask

  task automatic test_mode_change();
    req_mode_i = '0; req_valid_i = 2'b01; req_data_i[0] = mkvec(30);
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      n_tests++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL mode_fill c%0d: got %b exp 01", cyc, req_ready_o); end
      tick();
    end
    req_valid_i = 2'b10; req_mode_i[1] = 3'd2; req_data_i[1] = mkvec(31);
    for (int cyc = 3; cyc < 9; cyc++) begin
      perm_out_valid_i = (cyc >= 6);
      #1;
      n_tests++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL mode_drain_hold c%0d: got %b exp 00", cyc, req_ready_o); end
      if (cyc >= 6) begin
        n_tests++; if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL mode_drain_rsp c%0d: got %b exp 01", cyc, rsp_valid_o); end
      end
      tick();
    end
    perm_out_valid_i = 1'b0;
    #1;
    n_tests++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL mode_accept: got %b exp 10", req_ready_o); end
    tick();
    // A mode-2 request from requester 0 must go straight through: no drain once cur_mode is 2.
    req_valid_i = 2'b01; req_mode_i[0] = 3'd2; req_data_i[0] = mkvec(32);
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b1 || perm_mode_o !== 3'd2) begin n_fail++; $display("FAIL mode_issue: got v=%b m=%0d exp v=1 m=2", perm_in_valid_o, perm_mode_o); end
    n_tests++; if (perm_in_data_o !== mkvec(31)) begin n_fail++; $display("FAIL mode_issue_data: got word0 %h", perm_in_data_o[0]); end
    n_tests++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL mode_new_cur: got %b exp 01", req_ready_o); end
    tick();
    req_valid_i = 2'b00;
    #1;
    n_tests++; if (perm_in_data_o !== mkvec(32)) begin n_fail++; $display("FAIL mode_issue2_data: got word0 %h", perm_in_data_o[0]); end
    tick();
    perm_out_valid_i = 1'b1;
    #1;
    n_tests++; if (rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL mode_rsp_a: got %b exp 10", rsp_valid_o); end
    tick();
    n_tests++; if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL mode_rsp_b: got %b exp 01", rsp_valid_o); end
    tick();
    perm_out_valid_i = 1'b0;
  endtask

  task automatic test_index_load();
    req_valid_i = 2'b10; req_sel_idx_i = 2'b00; req_mode_i = {3'd2, 3'd2}; req_data_i[1] = mkvec(40);
    #1;
    n_tests++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL idx_pre_accept: got %b exp 10", req_ready_o); end
    tick();
    req_valid_i = 2'b01; req_sel_idx_i = 2'b01; req_data_i[0] = mkvec(41);
    #1;
    n_tests++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL idx_wait0: got %b exp 00", req_ready_o); end
    tick();
    n_tests++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL idx_wait1: got %b exp 00", req_ready_o); end
    tick();
    perm_out_valid_i = 1'b1;
    #1;
    n_tests++; if (rsp_valid_o !== 2'b10 || req_ready_o !== 2'b00) begin n_fail++; $display("FAIL idx_drain_rsp: got rsp=%b rdy=%b exp 10/00", rsp_valid_o, req_ready_o); end
    tick();
    perm_out_valid_i = 1'b0;
    #1;
    n_tests++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL idx_accept: got %b exp 01", req_ready_o); end
    tick();
    req_valid_i = 2'b00;
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b1 || perm_sel_idx_val_o !== 1'b1) begin n_fail++; $display("FAIL idx_issue: got v=%b s=%b exp 1/1", perm_in_valid_o, perm_sel_idx_val_o); end
    n_tests++; if (perm_in_data_o !== mkvec(41)) begin n_fail++; $display("FAIL idx_issue_data: got word0 %h", perm_in_data_o[0]); end
    tick();
    n_tests++; if ({perm_in_valid_o, perm_out_ready_o, rsp_valid_o} !== 4'b0000) begin n_fail++; $display("FAIL idx_no_tag: got %b exp 0000", {perm_in_valid_o, perm_out_ready_o, rsp_valid_o}); end
    req_sel_idx_i = 2'b00;
  endtask

  task automatic test_backpressure();
    req_mode_i = {3'd2, 3'd2}; req_data_i[1] = mkvec(50);
    for (int cyc = 0; cyc < 5; cyc++) begin
      req_valid_i = 2'b10;
      #1;
      n_tests++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL bp_accept c%0d: got %b exp 10", cyc, req_ready_o); end
      n_tests++; if (perm_in_valid_o !== (cyc >= 1)) begin n_fail++; $display("FAIL bp_in_valid c%0d: got %b exp %b", cyc, perm_in_valid_o, (cyc >= 1)); end
      tick();
    end
    req_valid_i = 2'b00; perm_out_valid_i = 1'b1; rsp_ready_i = 2'b00;
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_block: got %b exp 0", perm_in_valid_o); end
    n_tests++; if (rsp_valid_o !== 2'b10 || perm_out_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_stall: got rsp=%b rdy=%b exp 10/0", rsp_valid_o, perm_out_ready_o); end
    tick();
    n_tests++; if (perm_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold: got %b exp 0", perm_in_valid_o); end
    tick();
    rsp_ready_i = 2'b10;
    #1;
    n_tests++; if (perm_out_ready_o !== 1'b1 || perm_in_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_same_cycle_credit: got rdy=%b v=%b exp 1/0", perm_out_ready_o, perm_in_valid_o); end
    tick();
    perm_out_valid_i = 1'b0;
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_reassert: got %b exp 1", perm_in_valid_o); end
    tick();
    perm_out_valid_i = 1'b1; rsp_ready_i = 2'b11;
    tick();
    tick();
    perm_out_valid_i = 1'b0; req_valid_i = 2'b10;
    #1;
    n_tests++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL bp_refill: got %b exp 10", req_ready_o); end
    tick();
  endtask

  // Entered with two results outstanding and one vector waiting in the issue stage.
  task automatic test_reset_mid();
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_issue: got %b exp 1", perm_in_valid_o); end
    perm_out_valid_i = 1'b1;
    #1;
    n_tests++; if (rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre_rsp: got %b exp 10", rsp_valid_o); end
    rst_ni = 1'b0;
    #1;
    n_tests++; if ({perm_in_valid_o, perm_out_ready_o, rsp_valid_o, req_ready_o} !== 6'b0) begin n_fail++; $display("FAIL rstmid_async: got %b exp 000000", {perm_in_valid_o, perm_out_ready_o, rsp_valid_o, req_ready_o}); end
    n_tests++; if (perm_in_data_o !== '0 || perm_mode_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_data: got word0 %h mode %0d exp 0", perm_in_data_o[0], perm_mode_o); end
    perm_out_valid_i = 1'b0; req_valid_i = 2'b00;
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    n_tests++; if ({perm_out_ready_o, perm_in_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_fifo_empty: got %b exp 00", {perm_out_ready_o, perm_in_valid_o}); end
    req_valid_i = 2'b01; req_mode_i = '0; req_data_i[0] = mkvec(60);
    #1;
    n_tests++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL rstmid_mode0_accept: got %b exp 01", req_ready_o); end
    tick();
    req_valid_i = 2'b00;
    #1;
    n_tests++; if (perm_in_valid_o !== 1'b1 || perm_in_data_o !== mkvec(60)) begin n_fail++; $display("FAIL rstmid_reissue: got v=%b word0 %h", perm_in_valid_o, perm_in_data_o[0]); end
    tick();
    perm_out_valid_i = 1'b1; perm_out_data_i = mkvec(61);
    #1;
    n_tests++; if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL rstmid_rsp: got %b exp 01", rsp_valid_o); end
    tick();
    perm_out_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_ni           = 1'b0;
    req_valid_i      = '0;
    req_sel_idx_i    = '0;
    req_permute_i    = '0;
    req_mode_i       = '0;
    req_data_i       = '0;
    rsp_ready_i      = 2'b11;
    perm_in_ready_i  = 1'b1;
    perm_out_valid_i = 1'b0;
    perm_out_data_i  = '0;

    test_reset();
    test_single();
    test_contention();
    test_mode_change();
    test_index_load();
    test_backpressure();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
